// File: rtl/bambu_slave_loader.sv
// Front-end sequencer for a Bambu-generated `main` accelerator.
// Preloads accelerator memory byte by byte through slave channel 0, pulses
// start_port, counts cycles until done_port (with a timeout), reads back a
// result window through the same slave channel and streams it out, then
// pulses report once cyc_count/status are final.
module bambu_slave_loader #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SIZE_W  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_len,
    input  logic [ADDR_W-1:0]     cfg_rd_len,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [7:0]            byte_data,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy,
    output logic                  start_port,
    input  logic                  done_port,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [7:0]            rd_data,
    output logic [CNT_W-1:0]      cyc_count,
    output logic [1:0]            status,
    output logic                  report
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_OUT  = 3'd6,
        ST_REPORT  = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(4'd8);

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   len_r;
    logic [ADDR_W-1:0]   rd_len_r;
    logic [ADDR_W-1:0]   index_r;
    logic [CNT_W-1:0]    cyc_count_r;
    logic [1:0]          status_r;
    logic [7:0]          rd_data_r;
    logic                cfg_ready_r;

    logic [ADDR_W-1:0]   addr_s;
    logic [ADDR_W-1:0]   idx_next_s;
    logic [CNT_W-1:0]    cyc_inc_s;
    logic                we_s;
    logic                oe_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_wdata_s;
    logic [SIZE_W-1:0]   acc_size_s;
    logic                unused_s;

    // Address wraps modulo 2^ADDR_W simply by truncation of the sum.
    assign addr_s     = base_r + index_r;
    assign idx_next_s = index_r + ADDR_ONE;
    assign cyc_inc_s  = cyc_count_r + CNT_ONE;

    // The upper slave channel and its ready bit are never consumed.
    assign unused_s = ^{Sout_Rdata_ram[2*DATA_W-1:8], Sout_DataRdy[1]};

    // Slave channel 0 request: write on a LOAD byte handshake, read in RD_REQ.
    always_comb begin
        we_s        = 1'b0;
        oe_s        = 1'b0;
        acc_addr_s  = ADDR_ZERO;
        acc_wdata_s = {DATA_W{1'b0}};
        acc_size_s  = {SIZE_W{1'b0}};
        case (state_r)
            ST_LOAD: begin
                if (byte_valid) begin
                    we_s        = 1'b1;
                    acc_addr_s  = addr_s;
                    acc_wdata_s = DATA_W'(byte_data);
                    acc_size_s  = SIZE_BYTE;
                end else begin
                    we_s        = 1'b0;
                end
            end
            ST_RD_REQ: begin
                oe_s       = 1'b1;
                acc_addr_s = addr_s;
                acc_size_s = SIZE_BYTE;
            end
            default: begin
                we_s = 1'b0;
                oe_s = 1'b0;
            end
        endcase
    end

    assign S_we_ram        = {1'b0, we_s};
    assign S_oe_ram        = {1'b0, oe_s};
    assign S_addr_ram      = {ADDR_ZERO, acc_addr_s};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, acc_wdata_s};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, acc_size_s};

    assign cfg_ready  = cfg_ready_r;
    assign byte_ready = (state_r == ST_LOAD);
    assign start_port = (state_r == ST_START);
    assign rd_valid   = (state_r == ST_RD_OUT);
    assign report     = (state_r == ST_REPORT);
    assign rd_data    = rd_data_r;
    assign cyc_count  = cyc_count_r;
    assign status     = status_r;

    // Main sequencer: config, preload, start, run timing, readback, report.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            base_r      <= ADDR_ZERO;
            len_r       <= ADDR_ZERO;
            rd_len_r    <= ADDR_ZERO;
            index_r     <= ADDR_ZERO;
            cyc_count_r <= {CNT_W{1'b0}};
            status_r    <= 2'b00;
            rd_data_r   <= 8'h00;
            cfg_ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_r) begin
                        base_r      <= cfg_base;
                        len_r       <= cfg_len;
                        rd_len_r    <= cfg_rd_len;
                        index_r     <= ADDR_ZERO;
                        status_r    <= 2'b00;
                        cyc_count_r <= {CNT_W{1'b0}};
                        cfg_ready_r <= 1'b0;
                        state_r     <= (cfg_len != ADDR_ZERO) ? ST_LOAD : ST_START;
                    end else begin
                        // cfg_ready rises one cycle after reset releases.
                        cfg_ready_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (byte_valid) begin
                        if (idx_next_s == len_r) begin
                            index_r <= ADDR_ZERO;
                            state_r <= ST_START;
                        end else begin
                            index_r <= idx_next_s;
                        end
                    end
                end
                ST_START: begin
                    cyc_count_r <= CNT_ONE;
                    state_r     <= ST_RUN;
                end
                ST_RUN: begin
                    // Count is inclusive; done wins over a coincident timeout.
                    cyc_count_r <= cyc_inc_s;
                    if (done_port) begin
                        status_r <= 2'b01;
                        state_r  <= (rd_len_r != ADDR_ZERO) ? ST_RD_REQ : ST_REPORT;
                    end else if (cyc_inc_s >= TIMEOUT_C) begin
                        status_r <= 2'b10;
                        state_r  <= ST_REPORT;
                    end else begin
                        state_r  <= ST_RUN;
                    end
                end
                ST_RD_REQ: begin
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (Sout_DataRdy[0]) begin
                        rd_data_r <= Sout_Rdata_ram[7:0];
                        state_r   <= ST_RD_OUT;
                    end
                end
                ST_RD_OUT: begin
                    if (rd_ready) begin
                        if (idx_next_s == rd_len_r) begin
                            index_r <= ADDR_ZERO;
                            state_r <= ST_REPORT;
                        end else begin
                            index_r <= idx_next_s;
                            state_r <= ST_RD_REQ;
                        end
                    end
                end
                ST_REPORT: begin
                    cfg_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bambu_slave_loader.sv
// Directed bench for bambu_slave_loader: preload, timing, wrap, readback,
// timeout and mid-load reset, against hand-computed expectations.
module tb_bambu_slave_loader;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_base;
    logic [6:0]  cfg_len;
    logic [6:0]  cfg_rd_len;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic        start_port;
    logic        done_port;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic [31:0] cyc_count;
    logic [1:0]  status;
    logic        report;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] mem [0:127];

    bambu_slave_loader #(.TIMEOUT(10)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_rd_len(cfg_rd_len),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .start_port(start_port), .done_port(done_port),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .cyc_count(cyc_count), .status(status), .report(report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cfg(input logic [6:0] b, input logic [6:0] l, input logic [6:0] r);
        int n;
        n = 0;
        while (!cfg_ready && n < 10) begin
            tick();
            n++;
        end
        chk("cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_base   = b;
        cfg_len    = l;
        cfg_rd_len = r;
        tick();
        cfg_valid  = 1'b0;
        #1;
        chk("cfg_ready_low", 32'(cfg_ready), 32'd0);
    endtask

    task automatic send_byte(input logic [6:0] a, input logic [7:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        #1;
        chk("we", 32'(S_we_ram), 32'h1);
        chk("we_addr", 32'(S_addr_ram), 32'(a));
        chk("we_data", 32'(S_Wdata_ram), 32'(d));
        chk("we_size", 32'(S_data_ram_size), 32'h08);
        tick();
        byte_valid = 1'b0;
    endtask

    // Called in the START cycle; done asserted n cycles after start.
    task automatic do_run(input int n);
        chk("start", 32'(start_port), 32'd1);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) chk("start_pulse", 32'(start_port), 32'd0);
        end
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        #1;
    endtask

    task automatic wait_rd(output int n);
        n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_valid", 32'(rd_valid), 32'd1);
    endtask

    // Accelerator RAM model on slave channel 0, read latency 2 cycles.
    initial begin
        int pend;
        logic [7:0] pdata;
        pend = 0;
        pdata = 8'h00;
        Sout_DataRdy = 2'b00;
        Sout_Rdata_ram = 16'h0000;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clock);
            Sout_DataRdy = 2'b00;
            Sout_Rdata_ram = 16'hEEEE;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    Sout_DataRdy = 2'b01;
                    Sout_Rdata_ram = {8'hEE, pdata};
                end
            end
            if (S_we_ram[0]) begin
                mem[S_addr_ram[6:0]] = S_Wdata_ram[7:0];
                we_cnt++;
            end
            if (S_oe_ram[0]) begin
                pdata = mem[S_addr_ram[6:0]];
                pend = 2;
                oe_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int oe0;
        int we0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_base = 7'd0; cfg_len = 7'd0;
        cfg_rd_len = 7'd0; byte_valid = 1'b0; byte_data = 8'h00;
        done_port = 1'b0; rd_ready = 1'b0;
        tick();
        tick();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_cyc", cyc_count, 32'd0);
        chk("rst_report", 32'(report), 32'd0);
        chk("rst_start", 32'(start_port), 32'd0);
        reset = 1'b0;

        // Preload 4 bytes back-to-back, done on first RUN cycle.
        send_cfg(7'h10, 7'd4, 7'd0);
        chk("byte_ready", 32'(byte_ready), 32'd1);
        send_byte(7'h10, 8'hA1);
        send_byte(7'h11, 8'hB2);
        send_byte(7'h12, 8'hC3);
        send_byte(7'h13, 8'hD4);
        chk("load_done_we", 32'(S_we_ram), 32'd0);
        do_run(1);
        chk("t1_report", 32'(report), 32'd1);
        chk("t1_cyc", cyc_count, 32'd2);
        chk("t1_we_cnt", 32'(we_cnt), 32'd4);
        tick();
        chk("t1_report_pulse", 32'(report), 32'd0);

        // len=0: straight to START, done 5 cycles after start.
        we0 = we_cnt;
        send_cfg(7'h40, 7'd0, 7'd0);
        do_run(5);
        chk("t2_report", 32'(report), 32'd1);
        chk("t2_cyc", cyc_count, 32'd6);
        chk("t2_status", 32'(status), 32'd1);
        tick();
        chk("t2_report_pulse", 32'(report), 32'd0);
        chk("t2_cyc_hold", cyc_count, 32'd6);
        chk("t2_status_hold", 32'(status), 32'd1);
        chk("t2_no_we", 32'(we_cnt - we0), 32'd0);

        // Address wrap.
        send_cfg(7'h7E, 7'd3, 7'd0);
        send_byte(7'h7E, 8'h11);
        send_byte(7'h7F, 8'h22);
        send_byte(7'h00, 8'h33);
        do_run(2);
        chk("t3_cyc", cyc_count, 32'd3);
        tick();

        // Readback of 2 bytes with latency 2 and consumer back-pressure.
        oe0 = oe_cnt;
        send_cfg(7'h7E, 7'd0, 7'd2);
        do_run(3);
        chk("t4_oe", 32'(S_oe_ram), 32'h1);
        chk("t4_oe_addr", 32'(S_addr_ram), 32'h7E);
        chk("t4_oe_size", 32'(S_data_ram_size), 32'h08);
        wait_rd(n);
        chk("t4_rd_lat", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", 32'(rd_valid), 32'd1);
            chk("t4_hold_data", 32'(rd_data), 32'h11);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t4_oe2_addr", 32'(S_addr_ram), 32'h7F);
        wait_rd(n);
        chk("t4_data2", 32'(rd_data), 32'h22);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t4_report", 32'(report), 32'd1);
        chk("t4_status", 32'(status), 32'd1);
        chk("t4_cyc", cyc_count, 32'd4);
        chk("t4_oe_cnt", 32'(oe_cnt - oe0), 32'd2);
        tick();

        // Timeout with readback requested: no reads happen.
        oe0 = oe_cnt;
        send_cfg(7'h50, 7'd0, 7'd2);
        chk("t5_start", 32'(start_port), 32'd1);
        n = 0;
        while (!report && n < 30) begin
            tick();
            n++;
        end
        chk("t5_report_at", 32'(n), 32'd10);
        chk("t5_status", 32'(status), 32'd2);
        chk("t5_cyc", cyc_count, 32'd10);
        chk("t5_no_oe", 32'(oe_cnt - oe0), 32'd0);
        tick();

        // Reset during LOAD after 2 bytes, then a normal transaction.
        send_cfg(7'h20, 7'd4, 7'd0);
        send_byte(7'h20, 8'hAA);
        send_byte(7'h21, 8'hBB);
        byte_valid = 1'b1;
        byte_data  = 8'hCC;
        reset = 1'b1;
        tick();
        chk("t6_byte_ready", 32'(byte_ready), 32'd0);
        chk("t6_we", 32'(S_we_ram), 32'd0);
        chk("t6_addr", 32'(S_addr_ram), 32'd0);
        chk("t6_wdata", 32'(S_Wdata_ram), 32'd0);
        chk("t6_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("t6_start", 32'(start_port), 32'd0);
        reset = 1'b0;
        byte_valid = 1'b0;
        send_cfg(7'h30, 7'd1, 7'd1);
        send_byte(7'h30, 8'h5A);
        do_run(2);
        wait_rd(n);
        chk("t6_rd_data", 32'(rd_data), 32'h5A);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t6_report", 32'(report), 32'd1);
        chk("t6_cyc", cyc_count, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bambu_slave_loader.md
Name: bambu_slave_loader

Overview:
- Synthesizable front-end for a Bambu-generated `main` accelerator.
- Takes a configuration word and a byte stream, preloads accelerator memory through the slave RAM port (channel 0), pulses start_port, and measures cycles until done_port.
- Then reads back a result window through the same slave port and streams it out.
- Sits directly upstream of the accelerator; replaces the file-driven preload/start/done sequencing with hardware.

Parameters:
- ADDR_W, 7, per-channel slave address width (port carries 2 channels).
- DATA_W, 8, per-channel slave data width; byte-granular preload.
- SIZE_W, 4, per-channel S_data_ram_size width.
- CNT_W, 32, cycle-counter width.
- TIMEOUT, 200000000, run-cycle limit before abort.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  high only in IDLE.
- cfg_base  in  ADDR_W  first byte address for preload and readback.
- cfg_len  in  ADDR_W  number of preload bytes (0 allowed).
- cfg_rd_len  in  ADDR_W  number of readback bytes (0 allowed).
- byte_valid  in  1  preload byte offered.
- byte_ready  out  1  high only in LOAD.
- byte_data  in  8  preload byte.
- S_oe_ram  out  2  slave read enable; bit 1 always 0.
- S_we_ram  out  2  slave write enable; bit 1 always 0.
- S_addr_ram  out  2*ADDR_W  slave address; upper channel 0.
- S_Wdata_ram  out  2*DATA_W  slave write data; upper channel 0.
- S_data_ram_size  out  2*SIZE_W  access size; channel 0 = 8 during an access, else 0.
- Sout_Rdata_ram  in  2*DATA_W  slave read data.
- Sout_DataRdy  in  2  read data valid; only bit 0 used.
- start_port  out  1  accelerator start pulse.
- done_port  in  1  accelerator completion.
- rd_valid  out  1  readback byte valid.
- rd_ready  in  1  readback consumer ready.
- rd_data  out  8  readback byte.
- cyc_count  out  CNT_W  measured run cycles.
- status  out  2  00 none, 01 ok, 10 timeout.
- report  out  1  one-cycle pulse when status/cyc_count are final.

Behaviour:
- **Reset:** all outputs 0, state IDLE, internal index 0, cyc_count 0, status 00. Reset mid-operation aborts immediately; start_port and all slave enables are 0 in the cycle after reset is sampled.
- **States:** IDLE, LOAD, START, RUN, RD_REQ, RD_WAIT, RD_OUT, REPORT.
- **IDLE:**
  - cfg_ready=1; cfg_valid&cfg_ready latches base/len/rd_len, clears index, clears status.
  - Next state is LOAD if len!=0, else START.
- **LOAD:**
  - byte_ready=1; each byte_valid&byte_ready cycle drives, combinationally in that cycle, S_we_ram[0]=1, addr=base+index (mod 2^ADDR_W), Wdata[7:0]=byte_data, size[3:0]=8.
  - One byte per cycle, no gaps required. No write when byte_valid=0.
  - After byte number len: clear index, go to START.
- **START:** start_port=1 for exactly one cycle; cyc_count loaded with 1; go to RUN.
- **RUN:**
  - cyc_count increments each cycle done_port=0.
  - On done_port=1, cyc_count is held at the value it had entering that cycle, plus 1 (inclusive count); status=01. Go to RD_REQ if rd_len!=0, else REPORT.
  - done_port is ignored outside RUN.
  - If cyc_count reaches TIMEOUT with done_port still 0: status=10, go to REPORT with no readback.
  - Simultaneous done and timeout resolves to done (status 01).
- **RD_REQ:** one cycle S_oe_ram[0]=1, addr=base+index, size=8; go to RD_WAIT.
- **RD_WAIT:**
  - Wait for Sout_DataRdy[0]=1 (minimum 1 cycle; any delay accepted).
  - Capture Sout_Rdata_ram[7:0] into rd_data; go to RD_OUT.
- **RD_OUT:**
  - rd_valid=1 with rd_data held stable until rd_ready=1.
  - On handshake, index+1. If index=rd_len, go to REPORT, else RD_REQ.
- **REPORT:** report=1 for one cycle; cyc_count and status hold until the next accepted cfg; return to IDLE.
- **Address wrap:** base+index wraps modulo 2^ADDR_W silently.

Test Plan:
- cfg base=0x10 len=4 rd_len=0, bytes A1,B2,C3,D4 back-to-back -> 4 consecutive we cycles at addr 0x10..0x13 with those data, size nibble 8; then one start_port pulse.
- len=0 rd_len=0, model asserts done_port 5 cycles after start -> no we cycles; cyc_count=6, status=01, single report pulse.
- base=0x7E len=3 -> writes at 0x7E, 0x7F, 0x00 (wrap).
- Readback rd_len=2, model DataRdy latency 2, rd_ready held low 3 cycles -> rd_data stable while rd_valid high; bytes delivered in address order; report after 2nd handshake.
- TIMEOUT overridden to 10, done never asserted -> status=10, cyc_count=10, no oe cycles, report pulse.
- reset asserted during LOAD after 2 bytes -> next cycle all outputs 0, state IDLE; new cfg accepted normally.
